// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Operand magnitudes are formed at MAX_W+1 bits so that the most negative value stays representable.
package div_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    LOAD   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  // Widest operand the magnitude helper accepts; X and Y must not exceed it.
  localparam int MAX_W = 64;

  localparam int X_DEF = 32;
  localparam int Y_DEF = 32;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(X_DEF);

  // Callers sign-extend their operand to MAX_W bits before calling.
  function automatic logic [MAX_W:0] abs_ext(input logic signed [MAX_W-1:0] value);
    logic [MAX_W:0] ext;
    ext = {value[MAX_W-1], value};
    return value[MAX_W-1] ? -ext : ext;
  endfunction

endpackage

// File: rtl/seq_divider_fsm_div_step.sv
// One restoring shift-subtract iteration on magnitudes.
// The quotient register shifts its MSB into the partial remainder and receives the new quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int X = 32,
  parameter int Y = 32
) (
  input  logic [Y:0]   prem,
  input  logic [X-1:0] qreg,
  input  logic [Y-1:0] abs_divisor,
  output logic [Y:0]   prem_next,
  output logic [X-1:0] qreg_next
);

  logic [Y:0]   shifted;
  logic [Y+1:0] trial;
  logic         unused_prem_msb;

  // The partial remainder is always below the divisor magnitude, so its MSB is zero here.
  assign unused_prem_msb = prem[Y];

  assign shifted = {prem[Y-1:0], qreg[X-1]};
  assign trial   = {1'b0, shifted} - {2'b00, abs_divisor};

  always_comb begin
    if (!trial[Y+1]) begin
      prem_next = trial[Y:0];
      qreg_next = {qreg[X-2:0], 1'b1};
    end else begin
      prem_next = shifted;
      qreg_next = {qreg[X-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_fsm.sv
// Sequential signed radix-2 divider: captures operands in LOAD, runs X restoring iterations,
// then registers sign-corrected quotient/remainder together with done.
//
// state  | meaning
// INIT   | idle after reset, outputs zero, done high
// LOAD   | capturing operand magnitudes and signs while load is held
// DIVIDE | one shift-subtract iteration per clock, counter 0..X-1
// DONE   | results held, done high, waiting for the next load
module seq_divider_fsm
  import div_pkg::*;
#(
  parameter int X = 32,
  parameter int Y = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [X-1:0] dividend,
  input  logic [Y-1:0] divisor,
  input  logic         load,
  output logic [X-1:0] quotient,
  output logic [Y-1:0] remainder,
  output logic         div_by_zero,
  output logic         done
);

  localparam int CW = cnt_width(X);

  if (Y > X || X > MAX_W) begin : g_width_check
    $error("seq_divider_fsm: widths must satisfy Y <= X <= MAX_W");
  end

  div_state_t state, state_nx;

  logic [Y:0]    prem, prem_nx;
  logic [X-1:0]  qreg, qreg_nx;
  logic [Y-1:0]  abs_dsr, abs_dsr_nx;
  logic [Y-1:0]  dvd_lo, dvd_lo_nx;
  logic          sign_q, sign_q_nx;
  logic          sign_r, sign_r_nx;
  logic          dbz_cap, dbz_cap_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [X-1:0]  quotient_nx;
  logic [Y-1:0]  remainder_nx;
  logic          div_by_zero_nx;
  logic          done_nx;

  logic [MAX_W:0] dvd_mag_w;
  logic [MAX_W:0] dsr_mag_w;
  logic           unused_mag;

  logic [Y:0]    step_prem;
  logic [X-1:0]  step_qreg;

  assign dvd_mag_w  = abs_ext(MAX_W'($signed(dividend)));
  assign dsr_mag_w  = abs_ext(MAX_W'($signed(divisor)));
  assign unused_mag = ^{dvd_mag_w, dsr_mag_w};

  div_step #(
    .X (X),
    .Y (Y)
  ) u_div_step (
    .prem        (prem),
    .qreg        (qreg),
    .abs_divisor (abs_dsr),
    .prem_next   (step_prem),
    .qreg_next   (step_qreg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      prem        <= '0;
      qreg        <= '0;
      abs_dsr     <= '0;
      dvd_lo      <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz_cap     <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b1;
    end else begin
      state       <= state_nx;
      prem        <= prem_nx;
      qreg        <= qreg_nx;
      abs_dsr     <= abs_dsr_nx;
      dvd_lo      <= dvd_lo_nx;
      sign_q      <= sign_q_nx;
      sign_r      <= sign_r_nx;
      dbz_cap     <= dbz_cap_nx;
      cnt         <= cnt_nx;
      quotient    <= quotient_nx;
      remainder   <= remainder_nx;
      div_by_zero <= div_by_zero_nx;
      done        <= done_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    prem_nx        = prem;
    qreg_nx        = qreg;
    abs_dsr_nx     = abs_dsr;
    dvd_lo_nx      = dvd_lo;
    sign_q_nx      = sign_q;
    sign_r_nx      = sign_r;
    dbz_cap_nx     = dbz_cap;
    cnt_nx         = cnt;
    quotient_nx    = quotient;
    remainder_nx   = remainder;
    div_by_zero_nx = div_by_zero;
    done_nx        = done;

    case (state)
      INIT: begin
        if (load) begin
          state_nx       = LOAD;
          done_nx        = 1'b0;
          div_by_zero_nx = 1'b0;
        end
      end

      LOAD: begin
        // Capture every cycle; whatever is present when load drops is used.
        prem_nx    = '0;
        qreg_nx    = dvd_mag_w[X-1:0];
        abs_dsr_nx = dsr_mag_w[Y-1:0];
        dvd_lo_nx  = dividend[Y-1:0];
        sign_q_nx  = dividend[X-1] ^ divisor[Y-1];
        sign_r_nx  = dividend[X-1];
        dbz_cap_nx = (divisor == '0);
        cnt_nx     = '0;
        done_nx    = 1'b0;
        state_nx   = load ? LOAD : DIVIDE;
      end

      DIVIDE: begin
        prem_nx = step_prem;
        qreg_nx = step_qreg;
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(X - 1)) begin
          state_nx       = DONE;
          cnt_nx         = '0;
          done_nx        = 1'b1;
          div_by_zero_nx = dbz_cap;
          if (dbz_cap) begin
            quotient_nx  = '1;
            remainder_nx = dvd_lo;
          end else begin
            quotient_nx  = sign_q ? -step_qreg : step_qreg;
            remainder_nx = sign_r ? -step_prem[Y-1:0] : step_prem[Y-1:0];
          end
        end
      end

      DONE: begin
        if (load) begin
          state_nx       = LOAD;
          done_nx        = 1'b0;
          div_by_zero_nx = 1'b0;
        end
      end

      default: begin
        state_nx = LOAD;
        done_nx  = 1'b0;
      end
    endcase
  end

endmodule
